// File: rtl/cpu_mmu_pt_access_seq.sv
// rtl/cpu_mmu_pt_access_seq.sv - page-table RAM access sequencer with four-phase REQ/ACK handshake
//
// Purpose: sequences one PT RAM read (PT -> IDB) or write (IDB -> PT) per
// accepted request, driving the PT RAM address/OE/WE strobes and the
// PT-to-IDB transceiver enable/direction. Wait-state lengths are parameters.
//
// Ports:
//   sysclk      in   system clock, rising edge
//   sys_rst     in   synchronous active-high reset
//   REQ         in   access request level (four-phase handshake)
//   RW          in   1 = write PT entry from IDB, 0 = read PT entry to IDB
//   PT_ADDR_IN  in   [7:0] PT entry address, sampled with REQ
//   ACK         out  access complete, held until REQ falls
//   BUSY        out  sequencer not idle
//   PT_ADDR     out  [7:0] latched PT RAM address
//   PT_OE_n     out  PT RAM output enable, active low
//   PT_WE_n     out  PT RAM write enable, active low
//   EPTI_n      out  transceiver enable, active low
//   WRITE       out  transceiver direction, 1 = IDB -> PT
module cpu_mmu_pt_access_seq #(
  parameter int RD_WAIT  = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 1
) (
  input  logic       sysclk,
  input  logic       sys_rst,
  input  logic       REQ,
  input  logic       RW,
  input  logic [7:0] PT_ADDR_IN,
  output logic       ACK,
  output logic       BUSY,
  output logic [7:0] PT_ADDR,
  output logic       PT_OE_n,
  output logic       PT_WE_n,
  output logic       EPTI_n,
  output logic       WRITE
);

  // Counter load value for an N-cycle state: N-1, with N clamped to 1..15.
  function automatic logic [3:0] load_val(input int n);
    if (n < 1) begin
      return 4'd0;
    end else if (n > 15) begin
      return 4'd14;
    end else begin
      return 4'(n - 1);
    end
  endfunction

  localparam logic [3:0] RD_LOAD = load_val(RD_WAIT);
  localparam logic [3:0] WS_LOAD = load_val(WR_SETUP);
  localparam logic [3:0] WP_LOAD = load_val(WR_PULSE);
  localparam logic [3:0] WH_LOAD = load_val(WR_HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       rw_q, rw_nxt;
  logic [7:0] addr_nxt;
  logic       ack_nxt, busy_nxt, oe_nxt, we_nxt, epti_nxt, write_nxt;

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rw_q    <= 1'b0;
      PT_ADDR <= 8'd0;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
      PT_OE_n <= 1'b1;
      PT_WE_n <= 1'b1;
      EPTI_n  <= 1'b1;
      WRITE   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rw_q    <= rw_nxt;
      PT_ADDR <= addr_nxt;
      ACK     <= ack_nxt;
      BUSY    <= busy_nxt;
      PT_OE_n <= oe_nxt;
      PT_WE_n <= we_nxt;
      EPTI_n  <= epti_nxt;
      WRITE   <= write_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rw_nxt    = rw_q;
    addr_nxt  = PT_ADDR;

    case (state)
      S_IDLE: begin
        if (REQ) begin
          addr_nxt = PT_ADDR_IN;
          rw_nxt   = RW;
          if (RW) begin
            state_nxt = S_WR_SETUP;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = S_RD_ADDR;
            cnt_nxt   = 4'd0;
          end
        end
      end
      S_RD_ADDR: begin
        state_nxt = S_RD_WAIT;
        cnt_nxt   = RD_LOAD;
      end
      S_RD_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_WR_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = S_WR_PULSE;
          cnt_nxt   = WP_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_WR_PULSE: begin
        if (cnt == 4'd0) begin
          state_nxt = S_WR_HOLD;
          cnt_nxt   = WH_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_WR_HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (!REQ) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    // Moore outputs decoded from the state being entered, so the registered
    // strobes line up with the state they describe.
    ack_nxt   = 1'b0;
    busy_nxt  = 1'b1;
    oe_nxt    = 1'b1;
    we_nxt    = 1'b1;
    epti_nxt  = 1'b1;
    write_nxt = 1'b0;

    case (state_nxt)
      S_IDLE: begin
        busy_nxt = 1'b0;
      end
      S_RD_ADDR: begin
        oe_nxt = 1'b0;
      end
      S_RD_WAIT: begin
        oe_nxt   = 1'b0;
        epti_nxt = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        write_nxt = 1'b1;
        epti_nxt  = 1'b0;
      end
      S_WR_PULSE: begin
        write_nxt = 1'b1;
        epti_nxt  = 1'b0;
        we_nxt    = 1'b0;
      end
      S_DONE: begin
        ack_nxt = 1'b1;
        // A read keeps the IDB driven while ACK is high; a write releases
        // the transceiver and direction together.
        if (!rw_nxt) begin
          oe_nxt   = 1'b0;
          epti_nxt = 1'b0;
        end
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_mmu_pt_access_seq.sv
// tb/tb_cpu_mmu_pt_access_seq.sv - self-checking bench for cpu_mmu_pt_access_seq
module tb_cpu_mmu_pt_access_seq;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr_in = 8'd0;

  logic       ack[3], busy[3], oe_n[3], we_n[3], epti_n[3], wr[3];
  logic [7:0] pt_addr[3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Instance 0: defaults; 1: parameter sweep; 2: zero pulse width.
  int p_rd[3] = '{2, 5, 2};
  int p_ws[3] = '{1, 3, 1};
  int p_wp[3] = '{2, 4, 0};
  int p_wh[3] = '{1, 2, 1};

  always #5 sysclk = ~sysclk;

  cpu_mmu_pt_access_seq u_dut0 (
    .sysclk(sysclk), .sys_rst(rst), .REQ(req), .RW(rw), .PT_ADDR_IN(addr_in),
    .ACK(ack[0]), .BUSY(busy[0]), .PT_ADDR(pt_addr[0]), .PT_OE_n(oe_n[0]),
    .PT_WE_n(we_n[0]), .EPTI_n(epti_n[0]), .WRITE(wr[0])
  );

  cpu_mmu_pt_access_seq #(.RD_WAIT(5), .WR_SETUP(3), .WR_PULSE(4), .WR_HOLD(2)) u_dut1 (
    .sysclk(sysclk), .sys_rst(rst), .REQ(req), .RW(rw), .PT_ADDR_IN(addr_in),
    .ACK(ack[1]), .BUSY(busy[1]), .PT_ADDR(pt_addr[1]), .PT_OE_n(oe_n[1]),
    .PT_WE_n(we_n[1]), .EPTI_n(epti_n[1]), .WRITE(wr[1])
  );

  cpu_mmu_pt_access_seq #(.RD_WAIT(2), .WR_SETUP(1), .WR_PULSE(0), .WR_HOLD(1)) u_dut2 (
    .sysclk(sysclk), .sys_rst(rst), .REQ(req), .RW(rw), .PT_ADDR_IN(addr_in),
    .ACK(ack[2]), .BUSY(busy[2]), .PT_ADDR(pt_addr[2]), .PT_OE_n(oe_n[2]),
    .PT_WE_n(we_n[2]), .EPTI_n(epti_n[2]), .WRITE(wr[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: per instance, whether a transaction is live,
  // its direction/address, and how many edges have passed since acceptance.
  bit         m_busy[3];
  bit         m_rw[3];
  logic [7:0] m_addr[3];
  int         m_j[3];

  function automatic int eff(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int done_at(input int i);
    if (m_rw[i]) return eff(p_ws[i]) + eff(p_wp[i]) + eff(p_wh[i]);
    return eff(p_rd[i]) + 1;
  endfunction

  // Packed expectation {ACK, BUSY, PT_ADDR, PT_OE_n, PT_WE_n, EPTI_n, WRITE}.
  function automatic logic [13:0] expv(input int i);
    logic a, b, o, w, e, d;
    int j, s, p;
    a = 0; b = 0; o = 1; w = 1; e = 1; d = 0;
    j = m_j[i];
    if (m_busy[i]) begin
      b = 1;
      if (j >= done_at(i)) begin
        a = 1;
        if (!m_rw[i]) begin o = 0; e = 0; end
      end else if (!m_rw[i]) begin
        o = 0;
        if (j >= 1) e = 0;
      end else begin
        s = eff(p_ws[i]);
        p = eff(p_wp[i]);
        d = 1; e = 0;
        if (j >= s && j < s + p) w = 0;
      end
    end
    return {a, b, m_addr[i], o, w, e, d};
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_rw[i] = 0; m_addr[i] = 8'd0; m_j[i] = 0;
    end
  end

  always @(posedge sysclk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] = 0;
        m_addr[i] = 8'd0;
        m_j[i] = 0;
      end else if (!m_busy[i]) begin
        if (req) begin
          m_busy[i] = 1; m_rw[i] = rw; m_addr[i] = addr_in; m_j[i] = 0;
        end
      end else if (m_j[i] >= done_at(i)) begin
        if (!req) m_busy[i] = 0;
      end else begin
        m_j[i] = m_j[i] + 1;
      end
    end
  end

  always @(negedge sysclk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("outputs[%0d]", i),
            32'({ack[i], busy[i], pt_addr[i], oe_n[i], we_n[i], epti_n[i], wr[i]}),
            32'(expv(i)));
        if (we_n[i] === 1'b0)
          chk($sformatf("we_guard[%0d]", i), 32'({wr[i], epti_n[i]}), 32'b10);
      end
    end
  end

  int af[3], ac[3], wl[3];

  task automatic wait_idle();
    int n;
    n = 0;
    req = 0;
    while ((m_busy[0] || m_busy[1] || m_busy[2]) && n < 60) begin
      @(negedge sysclk);
      n++;
    end
    chk("idle_wait_timeout", 32'(n < 60), 32'd1);
  endtask

  // Issue one request, hold REQ for 'hold' edges, record per-instance first
  // ACK index (edges after acceptance), ACK cycles and PT_WE_n low cycles.
  task automatic go(input bit w, input logic [7:0] a, input int hold);
    wait_idle();
    rst = 0; req = 1; rw = w; addr_in = a;
    for (int i = 0; i < 3; i++) begin af[i] = -1; ac[i] = 0; wl[i] = 0; end
    @(negedge sysclk);
    addr_in = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (ack[i] === 1'b1) begin
          ac[i]++;
          if (af[i] < 0) af[i] = k;
        end
        if (we_n[i] === 1'b0) wl[i]++;
      end
      if (k + 1 >= hold) req = 0;
      @(negedge sysclk);
    end
  endtask

  initial begin
    rst = 1; req = 1; rw = 0; addr_in = 8'hA5;
    repeat (2) @(negedge sysclk);
    cmp_en = 1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset[%0d]", i),
          32'({ack[i], busy[i], pt_addr[i], oe_n[i], we_n[i], epti_n[i], wr[i]}),
          32'b00_00000000_1110);

    // Default read, REQ held through DONE so ACK is held two cycles.
    go(0, 8'hA5, 5);
    chk("rd_ack_first_dflt", 32'(af[0]), 32'd3);
    chk("rd_ack_held_dflt", 32'(ac[0]), 32'd2);
    chk("rd_ack_first_sweep", 32'(af[1]), 32'd6);
    chk("rd_addr_dflt", 32'(pt_addr[0]), 32'hA5);

    // Default write with REQ dropped right after acceptance.
    go(1, 8'h3C, 1);
    chk("wr_ack_first_dflt", 32'(af[0]), 32'd4);
    chk("wr_we_cycles_dflt", 32'(wl[0]), 32'd2);
    chk("wr_ack_one_cycle", 32'(ac[0]), 32'd1);
    chk("wr_ack_first_sweep", 32'(af[1]), 32'd9);
    chk("wr_we_cycles_sweep", 32'(wl[1]), 32'd4);
    chk("wr_ack_first_p0", 32'(af[2]), 32'd3);
    chk("wr_we_cycles_p0", 32'(wl[2]), 32'd1);

    // Early REQ drop on a read; address input changes mid-sequence.
    go(0, 8'h5A, 1);
    chk("rd_early_ack_first", 32'(af[0]), 32'd3);
    chk("rd_early_ack_cycles", 32'(ac[0]), 32'd1);
    chk("rd_early_addr_kept", 32'(pt_addr[0]), 32'h5A);

    // Reset while the write strobe is low.
    wait_idle();
    req = 1; rw = 1; addr_in = 8'h11;
    @(negedge sysclk);
    req = 0;
    @(negedge sysclk);
    chk("midwr_we_low", 32'(we_n[0]), 32'd0);
    rst = 1;
    @(negedge sysclk);
    chk("midwr_reset", 32'({we_n[0], epti_n[0], wr[0], busy[0]}), 32'b1100);
    rst = 0;

    // Randomised traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 3) != 0);
      rw = 1'($urandom_range(0, 1));
      addr_in = 8'($urandom_range(0, 255));
      @(negedge sysclk);
    end
    rst = 0;
    wait_idle();
    @(negedge sysclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mmu_pt_access_seq.md
# cpu_mmu_pt_access_seq

Sequencer that controls a page-table (PT) RAM access on behalf of the CPU microcode. It drives the EPTI_n/WRITE controls of the 16-bit PT-to-IDB transceiver, and the PT RAM address, output-enable and write-enable strobes. It uses a four-phase REQ/ACK handshake with parameterised wait states. It sits in the CPU/MMU section between the microcode control decode and the PT RAM/transceiver pair.

## Interface
Parameters:
- RD_WAIT, 2, read access cycles with PT RAM output enabled before data is presented (1..15; 0 treated as 1)
- WR_SETUP, 1, cycles of address/data setup before the write strobe (1..15; 0 treated as 1)
- WR_PULSE, 2, PT_WE_n low cycles (1..15; 0 treated as 1)
- WR_HOLD, 1, cycles of address/data hold after the write strobe (1..15; 0 treated as 1)

Ports:
- sysclk  in  1  system clock; all state changes on the rising edge
- sys_rst  in  1  synchronous, active-high reset
- REQ  in  1  access request (level), four-phase handshake
- RW  in  1  1 = write PT entry from IDB, 0 = read PT entry to IDB; sampled with REQ
- PT_ADDR_IN  in  8  PT entry address (PIT[1:0], page[5:0]); sampled with REQ
- ACK  out  1  access complete; held until REQ low
- BUSY  out  1  sequencer not idle
- PT_ADDR  out  8  latched PT RAM address
- PT_OE_n  out  1  PT RAM output enable, active low
- PT_WE_n  out  1  PT RAM write enable, active low
- EPTI_n  out  1  transceiver enable, active low
- WRITE  out  1  transceiver direction: 1 = IDB->PT, 0 = PT->IDB

## Operation
- Reset: state IDLE, counter 0. Outputs: ACK=0, BUSY=0, PT_ADDR=0, PT_OE_n=1, PT_WE_n=1, EPTI_n=1, WRITE=0.
- All outputs are registered and are a function of the next state (Moore).
- States: IDLE, RD_ADDR, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: when REQ=1, latch PT_ADDR_IN into PT_ADDR and latch RW. Go to RD_ADDR if RW=0, else WR_SETUP. REQ=0 keeps the block in IDLE.
- RD_ADDR (1 cycle): PT_OE_n=0, EPTI_n=1, WRITE=0.
- RD_WAIT (RD_WAIT cycles): PT_OE_n=0, EPTI_n=0, WRITE=0.
- WR_SETUP (WR_SETUP cycles): WRITE=1, EPTI_n=0, PT_WE_n=1.
- WR_PULSE (WR_PULSE cycles): WRITE=1, EPTI_n=0, PT_WE_n=0.
- WR_HOLD (WR_HOLD cycles): WRITE=1, EPTI_n=0, PT_WE_n=1.
- DONE: ACK=1.
  - Read: PT_OE_n=0, EPTI_n=0, WRITE=0, so IDB stays driven while ACK is high.
  - Write: EPTI_n=1, WRITE=0, PT_WE_n=1.
  - Exit to IDLE on the first edge with REQ=0.
- Wait counter is 4 bits. It loads (N-1) on state entry, decrements each cycle, and leaves the state at 0.
- BUSY=1 in every state except IDLE, including DONE.
- REQ, RW and PT_ADDR_IN changes after acceptance are ignored. A sequence always completes.
- WRITE never changes while EPTI_n=0 within one transaction. PT_WE_n is never low unless WRITE=1 and EPTI_n=0.

## Timing
- Edge E0 samples REQ=1 in IDLE.
- Read: ACK first high after edge E0+1+RD_WAIT (default E3). PT_OE_n low from E0+1; EPTI_n low from E0+2.
- Write: ACK first high after edge E0+WR_SETUP+WR_PULSE+WR_HOLD (default E4). PT_WE_n low after edges E0+WR_SETUP .. E0+WR_SETUP+WR_PULSE-1.
- REQ already low when DONE is entered: ACK is high exactly one cycle, then IDLE.
- REQ held high through DONE: ACK is held. After REQ falls, IDLE is reached one edge later. A new REQ is accepted only on an edge where the block is in IDLE, so back-to-back transactions carry at least one idle cycle.
- sys_rst=1 at any edge, including mid-write during PT_WE_n=0: on that edge all outputs take their reset values and the state becomes IDLE. The PT write is truncated.
- Reset and REQ on the same edge: reset wins; the request is not accepted.

## Test plan
- Reset: assert sys_rst 2 cycles with REQ=1 -> all outputs at reset values; no acceptance until the cycle after reset is released.
- Default read: REQ=1, RW=0, PT_ADDR_IN=8'hA5 at E0 ->
  - PT_ADDR=A5 after E0.
  - PT_OE_n=0 after E0..until exit.
  - EPTI_n=0 and WRITE=0 after E1.
  - ACK=1 after E3, held while REQ=1; REQ dropped -> IDLE, all strobes high, BUSY=0.
- Default write: REQ=1, RW=1, PT_ADDR_IN=8'h3C ->
  - WRITE=1 and EPTI_n=0 after E0..E3.
  - PT_WE_n=0 only after E1 and E2.
  - ACK=1 after E4, with EPTI_n=1.
  - Checker asserts PT_WE_n=0 implies WRITE=1 and EPTI_n=0.
- Early REQ drop: REQ pulsed 1 cycle, read ->
  - Full read sequence still runs; ACK is high exactly one cycle.
  - PT_ADDR_IN changed to 8'hFF mid-sequence -> PT_ADDR stays at the original value.
- Mid-write reset: assert sys_rst while PT_WE_n=0 -> next edge PT_WE_n=1, EPTI_n=1, WRITE=0, BUSY=0.
- Parameter sweep: RD_WAIT=5, WR_SETUP=3, WR_PULSE=4, WR_HOLD=2 (plus a WR_PULSE=0 instance) ->
  - Read ACK after E6; write ACK after E9.
  - WR_PULSE=0 gives a 1-cycle PT_WE_n pulse.
